// File: rtl/riscy_pkg.sv
// Shared register-file geometry and dumper FSM state encoding.
package riscy_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StSend,
        StCsum
    } dump_state_t;

endpackage

// File: rtl/regdump_xor_acc.sv
// Running XOR of captured register values for the dump checksum beat.
// Only compiled when REGDUMP_CHECKSUM_EN is defined.
`ifdef REGDUMP_CHECKSUM_EN
module regdump_xor_acc #(
    parameter int unsigned Width = riscy_pkg::XLEN
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [Width-1:0] din_i,
    output logic [Width-1:0] acc_o
);

    logic [Width-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q ^ din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule
`endif

// File: rtl/regfile_dumper.sv
// Walks x0..x(NUM_REGS-1) through one register-file read port and streams them out.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum beat after the last register.
module regfile_dumper #(
    parameter int unsigned XLEN     = riscy_pkg::XLEN,
    parameter int unsigned NUM_REGS = riscy_pkg::NUM_REGS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic [$clog2(NUM_REGS)-1:0] rf_addr,
    input  logic [XLEN-1:0]             rf_rdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             out_data,
    output logic [$clog2(NUM_REGS):0]   out_idx,
    output logic                        out_last,
    output logic                        dump_done
);
    import riscy_pkg::*;

    localparam int unsigned AW = $clog2(NUM_REGS);
    localparam int unsigned IW = AW + 1;
    localparam logic [AW-1:0] LastIdx = AW'(NUM_REGS - 1);

    dump_state_t     state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [IW-1:0]   oidx_q, oidx_d;
    logic            is_last;
    logic            handshake;
    logic [XLEN-1:0] csum;

    assign is_last   = (idx_q == LastIdx);
    assign handshake = valid_q && out_ready;

`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CsumEn = 1'b1;

    regdump_xor_acc #(
        .Width(XLEN)
    ) u_xor_acc (
        .clk_i  (clk),
        .rst_i  (rst),
        .clear_i((state_q == StIdle) && start),
        .en_i   (state_q == StRead),
        .din_i  (rf_rdata),
        .acc_o  (csum)
    );
`else
    localparam bit CsumEn = 1'b0;

    assign csum = '0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        data_d  = data_q;
        oidx_d  = oidx_q;
        last_d  = last_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StRead;
                end
            end
            StRead: begin
                // Snapshot: later core writes to this register are not reflected in the beat.
                data_d  = rf_rdata;
                oidx_d  = {1'b0, idx_q};
                last_d  = is_last && !CsumEn;
                valid_d = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    if (!is_last) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StRead;
                    end else if (CsumEn) begin
                        data_d  = csum;
                        oidx_d  = IW'(NUM_REGS);
                        last_d  = 1'b1;
                        valid_d = 1'b1;
                        state_d = StCsum;
                    end else begin
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StCsum: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            oidx_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign rf_addr   = idx_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_idx   = oidx_q;
    assign out_last  = last_q;
    assign dump_done = done_q;

endmodule
